operand_select_pipe: RTL and testbench
======================================

# operand_select_pipe

Registered, parametrised operand selector for the single-cycle CPU datapath: picks one of NUM_IN data channels, a hard-wired constant, all-ones, the PC, or a replay of the last accepted value. The result is held in an output register with a valid/ready handshake so a downstream ALU or memory stage can stall it. An out-of-range selection is flagged as an error instead of silently keeping a stale value.

## Interface
- WIDTH, 17, data width of every channel, PC and output
- NUM_IN, 4, number of data channels on InBus (1..8)
- SEL_W, 4, Selection width; must satisfy 2^SEL_W >= NUM_IN+5
- CONST_A, 95 (0x5F), first hard-wired constant
- CONST_B, 200 (0xC8), second hard-wired constant

- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- InBus  in  NUM_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- PC  in  WIDTH  current program counter
- Selection  in  SEL_W  source code, sampled with InValid
- InValid  in  1  request present this cycle
- InReady  out  1  request accepted when InValid && InReady
- Output  out  WIDTH  registered selected value
- OutValid  out  1  Output holds an undelivered result
- OutReady  in  1  consumer takes Output when OutValid && OutReady
- SelError  out  1  one-cycle pulse: last accepted request had an illegal code
- ErrCount  out  8  only with OPSEL_ERRCNT_EN; see Configuration

## Operation
- Selection decode (N = NUM_IN): 0..N-1 -> channel k; N -> CONST_A; N+1 -> CONST_B; N+2 -> all ones; N+3 -> PC; N+4 -> Last (replay); any other code -> illegal.
- Constants zero-extended or truncated to WIDTH.
- Accept (InValid && InReady): Output <= decoded value, OutValid <= 1, Last <= decoded value.
- Illegal accept: Output <= 0, OutValid <= 1, Last unchanged, SelError <= 1 for one cycle.
- Legal accept or no accept: SelError <= 0.
- InReady = !OutValid || OutReady (combinational; single output stage, full throughput while consumer ready).
- Deliver without new accept: OutValid <= 0; Output retains its value.
- Deliver and accept in same cycle: new value loaded, OutValid stays 1.
- Stalled (OutValid && !OutReady): Output, OutValid, Last frozen; InReady = 0; inputs ignored.
- Replay uses Last as it was before the current accept; replay of a replay returns the same value.
- Last holds the most recent legal accepted value, never an illegal result.

## Timing
- Latency: accept in cycle t -> Output/OutValid visible cycle t+1.
- Throughput: one result per cycle when OutReady held high.
- Reset (any cycle, including mid-stall): Output=0, OutValid=0, SelError=0, Last=0, ErrCount=0; pending result discarded; InReady=1 the cycle after.
- Replay before any legal accept returns 0.
- Input channels and PC sampled only on the accept edge; changes while stalled have no effect.

## Configuration
- OPSEL_ERRCNT_EN defined: ErrCount port exists; 8-bit counter increments on every illegal accept, saturates at 255, cleared only by Reset.
- Not defined: ErrCount port and counter absent; SelError is the only error indication; all other behaviour identical.

## Test plan
- Reset, then NUM_IN=4, InBus channels 0x00011/0x00022/0x00033/0x00044, codes 0..3 back-to-back with OutReady=1 -> Outputs 0x11,0x22,0x33,0x44 on consecutive cycles, OutValid continuously 1.
- Codes 4,5,6,7 with PC=0x1F00 -> 0x0005F, 0x000C8, 0x1FFFF, 0x1F00.
- Code 1 (0x22), then code 8 -> replay 0x22; code 9 -> Output 0, SelError pulse one cycle, next code 8 still 0x22.
- Accept code 0, hold OutReady=0 three cycles while toggling InBus -> InReady=0, Output frozen at 0x11; release -> delivered once, next request accepted same cycle.
- Assert Reset during stall with OutValid=1 -> next cycle OutValid=0, Output=0, replay returns 0.
- With OPSEL_ERRCNT_EN: 260 illegal accepts -> ErrCount saturates at 255; Reset -> 0.

Source files
------------

// File: rtl/operand_select_pipe.sv
// Registered operand selector with a valid/ready output stage and replay of the last legal value.
// Optional feature macro OPSEL_ERRCNT_EN adds o_err_count, a saturating count of illegal accepts.
module operand_select_pipe #(
  parameter int          WIDTH   = 17,
  parameter int          NUM_IN  = 4,
  parameter int          SEL_W   = 4,
  parameter int unsigned CONST_A = 95,
  parameter int unsigned CONST_B = 200
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NUM_IN*WIDTH-1:0] i_in_bus,
  input  logic [WIDTH-1:0]        i_pc,
  input  logic [SEL_W-1:0]        i_selection,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  output logic [WIDTH-1:0]        o_output,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_sel_error
`ifdef OPSEL_ERRCNT_EN
  ,
  output logic [7:0]              o_err_count
`endif
);

  localparam logic [WIDTH-1:0] LP_CONST_A = WIDTH'(CONST_A);
  localparam logic [WIDTH-1:0] LP_CONST_B = WIDTH'(CONST_B);
  localparam logic [SEL_W-1:0] SEL_CA     = SEL_W'(NUM_IN);
  localparam logic [SEL_W-1:0] SEL_CB     = SEL_W'(NUM_IN + 1);
  localparam logic [SEL_W-1:0] SEL_ONES   = SEL_W'(NUM_IN + 2);
  localparam logic [SEL_W-1:0] SEL_PC     = SEL_W'(NUM_IN + 3);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_IN + 4);

  logic [WIDTH-1:0] r_output;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_last;
  logic             r_sel_error;
  logic [WIDTH-1:0] w_value;
  logic             w_legal;
  logic             w_accept;

  assign o_in_ready  = !r_out_valid || i_out_ready;
  assign w_accept    = i_in_valid && o_in_ready;
  assign o_output    = r_output;
  assign o_out_valid = r_out_valid;
  assign o_sel_error = r_sel_error;

  // Illegal codes leave w_value at zero, which is exactly what gets loaded.
  always_comb begin
    w_value = '0;
    w_legal = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (i_selection == SEL_W'(k)) begin
        w_value = i_in_bus[k*WIDTH +: WIDTH];
        w_legal = 1'b1;
      end
    end
    if (i_selection == SEL_CA) begin
      w_value = LP_CONST_A;
      w_legal = 1'b1;
    end
    if (i_selection == SEL_CB) begin
      w_value = LP_CONST_B;
      w_legal = 1'b1;
    end
    if (i_selection == SEL_ONES) begin
      w_value = '1;
      w_legal = 1'b1;
    end
    if (i_selection == SEL_PC) begin
      w_value = i_pc;
      w_legal = 1'b1;
    end
    if (i_selection == SEL_LAST) begin
      w_value = r_last;
      w_legal = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_output    <= '0;
      r_out_valid <= 1'b0;
      r_last      <= '0;
      r_sel_error <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_output    <= w_value;
      r_sel_error <= !w_legal;
      if (w_legal) r_last <= w_value;
    end else begin
      r_sel_error <= 1'b0;
      if (i_out_ready) r_out_valid <= 1'b0;
    end
  end

`ifdef OPSEL_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_err_count <= '0;
    end else if (w_accept && !w_legal && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign o_err_count = r_err_count;
`endif

endmodule

// File: tb/tb_operand_select_pipe.sv
// Randomized scoreboard bench for operand_select_pipe; reference model evaluates the selection rules directly.
module tb_operand_select_pipe;
  localparam int W  = 17;
  localparam int N  = 4;
  localparam int SW = 4;
  localparam int CA = 95;
  localparam int CB = 200;
  localparam int MASK = (1 << W) - 1;

  typedef struct {
    int v;
    bit e;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  bus;
  logic [W-1:0]    pc;
  logic [SW-1:0]   sel;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    dout;
  logic            out_valid;
  logic            out_ready;
  logic            sel_error;
`ifdef OPSEL_ERRCNT_EN
  logic [7:0]      err_count;
`endif

  operand_select_pipe #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .CONST_A(CA), .CONST_B(CB)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_in_bus   (bus),
    .i_pc       (pc),
    .i_selection(sel),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .o_output   (dout),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_sel_error(sel_error)
`ifdef OPSEL_ERRCNT_EN
    ,
    .o_err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_m   = 0;
  int   errc_m   = 0;
  bit   prev_stall = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: value chosen by a code, or -1 for an illegal code.
  function automatic int ref_value(input int code, input logic [N*W-1:0] b, input int p, input int lst);
    if (code < N) return int'((b >> (code * W)) & MASK);
    if (code == N)     return CA & MASK;
    if (code == N + 1) return CB & MASK;
    if (code == N + 2) return MASK;
    if (code == N + 3) return p & MASK;
    if (code == N + 4) return lst;
    return -1;
  endfunction

  // Driver entry point: called at posedge+1, returns at the following posedge+1.
  task automatic cycle(input bit v, input int code);
    bit   acc;
    exp_t e;
    int   r;
    in_valid = v;
    sel      = SW'(code);
    #3;
    acc = v && in_ready;
    r = ref_value(code, bus, int'(pc), last_m);
    e.e = (r < 0);
    e.v = e.e ? 0 : r;
    @(posedge clk);
    if (acc) begin
      q.push_back(e);
      if (!e.e) last_m = r;
      else if (errc_m < 255) errc_m++;
    end
    #1;
`ifdef OPSEL_ERRCNT_EN
    chk("err_count", int'(err_count), errc_m);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    q.delete();
    last_m = 0;
    errc_m = 0;
    #1;
    rst = 1'b0;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_output", int'(dout), 0);
    chk("reset_sel_error", int'(sel_error), 0);
    chk("reset_in_ready", int'(in_ready), 1);
`ifdef OPSEL_ERRCNT_EN
    chk("reset_err_count", int'(err_count), 0);
`endif
  endtask

  // Monitor: sampled on the falling edge, away from the update edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      chk("out_valid", int'(out_valid), int'(q.size() > 0));
      chk("in_ready", int'(in_ready), int'((q.size() == 0) || out_ready));
      if (out_valid && q.size() > 0) begin
        chk("output", int'(dout), q[0].v);
        chk("sel_error", int'(sel_error), int'(!prev_stall && q[0].e));
        if (out_ready) void'(q.pop_front());
      end else begin
        chk("sel_error_idle", int'(sel_error), 0);
      end
      prev_stall = out_valid && !out_ready;
    end
  end

  initial begin
    rst = 1'b1;
    bus = '0;
    pc = '0;
    sel = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    bus = {17'h00044, 17'h00033, 17'h00022, 17'h00011};
    pc  = 17'h01F00;
    for (int c = 0; c < 8; c++) cycle(1'b1, c);

    cycle(1'b1, 1);
    cycle(1'b1, 8);
    cycle(1'b1, 9);
    cycle(1'b1, 8);

    cycle(1'b1, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < N; k++) bus[k*W +: W] = W'($urandom);
      pc = W'($urandom);
      cycle(1'b1, i);
    end
    bus = {17'h00044, 17'h00033, 17'h00022, 17'h00011};
    out_ready = 1'b1;
    cycle(1'b1, 3);
    cycle(1'b0, 0);

    cycle(1'b1, 1);
    out_ready = 1'b0;
    cycle(1'b1, 2);
    do_reset();
    out_ready = 1'b1;
    cycle(1'b1, 8);
    cycle(1'b0, 0);

`ifdef OPSEL_ERRCNT_EN
    for (int i = 0; i < 260; i++) cycle(1'b1, 9 + (i % 7));
    chk("err_count_saturated", int'(err_count), 255);
    do_reset();
`endif

    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < N; k++) bus[k*W +: W] = W'($urandom);
      pc = W'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) cycle(1'b1, 8);
      else cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)));
    end

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 0);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
